// File: rtl/audio_tone_gen_if.sv
// audio_tone_gen_if: control inputs and sample outputs of the audio tone generator
interface audio_tone_gen_if #(
  parameter int CHANNELS    = 2,
  parameter int BIT_WIDTH   = 16,
  parameter int PHASE_WIDTH = 24
);
  logic                            enable;
  logic                            phase_sync;
  logic [2*CHANNELS-1:0]           mode;
  logic [PHASE_WIDTH*CHANNELS-1:0] increment;
  logic [3*CHANNELS-1:0]           attenuation;
  logic                            clk_audio;
  logic                            sample_valid;
  logic [BIT_WIDTH*CHANNELS-1:0]   audio_sample_word;
  modport master (
    output enable, phase_sync, mode, increment, attenuation,
    input  clk_audio, sample_valid, audio_sample_word
  );
  modport slave (
    input  enable, phase_sync, mode, increment, attenuation,
    output clk_audio, sample_valid, audio_sample_word
  );
endinterface

// File: rtl/audio_tone_gen.sv
// audio_tone_gen: multi-channel sawtooth/square/triangle test-tone source with audio clock divider
module audio_tone_gen #(
  parameter int CHANNELS    = 2,
  parameter int BIT_WIDTH   = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int HALF_PERIOD = 262
) (
  input  logic            clk_pixel,
  input  logic            reset_n,
  audio_tone_gen_if.slave bus
);
  localparam int B  = BIT_WIDTH;
  localparam int P  = PHASE_WIDTH;
  localparam int DW = $clog2(HALF_PERIOD + 1);
  localparam logic [B-1:0] SQ_HI = {1'b0, {(B-1){1'b1}}};
  localparam logic [B-1:0] SQ_LO = {1'b1, {(B-2){1'b0}}, 1'b1};
  logic [DW-1:0]         div_q, div_d;
  logic                  clk_q, clk_d, valid_q, tc, strobe;
  logic [P*CHANNELS-1:0] phase_q, phase_d;
  logic [B*CHANNELS-1:0] word_q, word_d;
  // divider wraps at terminal count; the falling toggle of clk_audio is the sample strobe
  always_comb begin
    tc     = div_q == DW'(HALF_PERIOD - 1);
    strobe = tc & clk_q;
    div_d  = tc ? '0 : div_q + DW'(1);
    clk_d  = clk_q ^ tc;
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic        [1:0]   m;
    logic        [2:0]   a;
    logic        [P-1:0] ph, inc;
    logic        [P-2:0] fold;
    logic signed [B-1:0] w, s;
    assign m    = bus.mode[2*c +: 2];
    assign a    = bus.attenuation[3*c +: 3];
    assign inc  = bus.increment[P*c +: P];
    assign ph   = phase_q[P*c +: P];
    assign fold = ph[P-1] ? ~ph[P-2:0] : ph[P-2:0];
    assign w    = m == 2'd0 ? '0 :
                  m == 2'd1 ? ph[P-1 -: B] :
                  m == 2'd2 ? (ph[P-1] ? SQ_LO : SQ_HI) :
                              {~fold[P-2], fold[P-3 -: B-1]};
    assign s    = w >>> a;
    assign word_d[B*c +: B]  = strobe ? s : word_q[B*c +: B];
    assign phase_d[P*c +: P] = bus.phase_sync ? '0 : (strobe && bus.enable) ? ph + inc : ph;
  end
  // all state registered, cleared asynchronously
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      clk_q   <= 1'b0;
      valid_q <= 1'b0;
      phase_q <= '0;
      word_q  <= '0;
    end else begin
      div_q   <= div_d;
      clk_q   <= clk_d;
      valid_q <= strobe;
      phase_q <= phase_d;
      word_q  <= word_d;
    end
  end
  assign bus.clk_audio         = clk_q;
  assign bus.sample_valid      = valid_q;
  assign bus.audio_sample_word = word_q;
endmodule
